// File: rtl/bus_protocol_pkg.sv
// Shared definitions for the bus protocol target: data width, FSM state
// encoding and the legal acknowledge-delay range.
package bus_protocol_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ACK_DLY_MIN = 1;
  localparam int unsigned ACK_DLY_MAX = 3;
  localparam int unsigned STATE_W     = 2;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bus_protocol_target_if.sv
// Master/target write handshake bundle.
//   dValid : master transfer-valid strobe
//   data   : master write data
//   dAck   : target acknowledge pulse
interface bus_protocol_target_if;
  import bus_protocol_pkg::*;

  logic  dValid;
  data_t data;
  logic  dAck;

  modport master (output dValid, output data, input dAck);
  modport slave  (input dValid, input data, output dAck);

endinterface

// File: rtl/bus_rx_fifo.sv
// Receive buffer with show-ahead read port.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   rdata      : current head entry, valid while empty=0
//   full/empty : registered occupancy flags
//   level      : number of stored entries
module bus_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "bus_rx_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when a pop frees the slot
  // in the same cycle.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + LW'(1);
      2'b01:   count_nxt = count - LW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == LW'(DEPTH));
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/bus_protocol_target.sv
// Write target: accepts one byte per dValid burst, acknowledges it after a
// programmable wait, and queues it in a receive FIFO for a local consumer.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   bus         : dValid/data in, dAck out (slave modport)
//   rd_en       : consumer pop request
//   rd_data     : FIFO head (show-ahead), valid while rd_empty=0
//   rd_empty    : FIFO empty
//   rd_full     : FIFO full
//   level       : FIFO occupancy
//   ovf         : sticky, an acknowledged byte was dropped on a full FIFO
//   err         : sticky, protocol violation seen
//   err_clr     : clears ovf and err (a coincident new event wins)
module bus_protocol_target
  import bus_protocol_pkg::*;
#(
  parameter int unsigned ACK_DLY    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  bus_protocol_target_if.slave         bus,
  input  logic                         rd_en,
  output data_t                        rd_data,
  output logic                         rd_empty,
  output logic                         rd_full,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         ovf,
  output logic                         err,
  input  logic                         err_clr
);

  if (ACK_DLY < ACK_DLY_MIN || ACK_DLY > ACK_DLY_MAX) begin : g_bad_ack_dly
    $fatal(1, "bus_protocol_target: ACK_DLY must be in 1..3");
  end

  localparam int unsigned       CNT_W    = $clog2(ACK_DLY_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_DLY - 1);

  localparam logic [STATE_W-1:0] IDLE = ST_IDLE;
  localparam logic [STATE_W-1:0] WAIT = ST_WAIT;
  localparam logic [STATE_W-1:0] ACK  = ST_ACK;
  localparam logic [STATE_W-1:0] DONE = ST_DONE;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  data_t              ref_q;
  data_t              ref_d;
  logic               dack_d;
  logic               ovf_d;
  logic               err_d;
  logic               push_c;
  logic               err_set_c;
  logic               ovf_set_c;

  // Next-state, FIFO push and error-event decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_d     = ref_q;
    push_c    = 1'b0;
    err_set_c = 1'b0;
    ovf_set_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dValid) begin
          state_d = WAIT;
          cnt_d   = '0;
          ref_d   = bus.data;
        end
      end
      WAIT: begin
        if (!bus.dValid) begin
          err_set_c = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          if (bus.data != ref_q) err_set_c = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ACK;
        end
      end
      ACK: begin
        if (!bus.dValid) begin
          err_set_c = 1'b1;
          state_d   = IDLE;
        end else begin
          if (bus.data != ref_q) err_set_c = 1'b1;
          // A same-cycle pop makes room even when the FIFO is full.
          push_c    = !rd_full || rd_en;
          ovf_set_c = !push_c;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.dValid) err_set_c = 1'b1;
        else            state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dack_d = (state_d == ACK);
    // Set has priority over clear so a coincident event is not lost.
    ovf_d  = ovf_set_c ? 1'b1 : (err_clr ? 1'b0 : ovf);
    err_d  = err_set_c ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      bus.dAck <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      bus.dAck <= dack_d;
      ovf      <= ovf_d;
      err      <= err_d;
    end
  end

  bus_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .wdata (bus.data),
    .pop   (rd_en),
    .rdata (rd_data),
    .full  (rd_full),
    .empty (rd_empty),
    .level (level)
  );

endmodule

// File: doc/bus_protocol_target.md
BUS_PROTOCOL_TARGET -- requirements
Module: bus_protocol_target

Interface
REQ-001 Parameter ACK_DLY, default 1, number of wait cycles between first dValid-high sample and dAck; legal 1..3.
REQ-002 Parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dValid  input  1  master transfer-valid strobe.
REQ-006 data  input  8  master write data.
REQ-007 dAck  output  1  target acknowledge; one-cycle pulse, registered.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  8  FIFO head, show-ahead; valid when rd_empty=0.
REQ-010 rd_empty  output  1  FIFO empty.
REQ-011 rd_full  output  1  FIFO full.
REQ-012 level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 ovf  output  1  sticky: accepted byte dropped because FIFO was full.
REQ-014 err  output  1  sticky: protocol violation (abort, unstable data, late dValid deassert).
REQ-015 err_clr  input  1  clears ovf and err, one-cycle pulse.

Function
REQ-016 FSM states IDLE, WAIT, ACK, DONE; dAck SHALL be 1 only in ACK.
REQ-017 IDLE: dValid=1 sampled in cycle T -> WAIT, wait counter=0, data latched into ref register.
REQ-018 WAIT: counter increments each cycle; when counter=ACK_DLY-1 and dValid=1 -> ACK; dAck therefore high exactly in cycle T+ACK_DLY+1.
REQ-019 WAIT or ACK with dValid=0 sampled -> err set, no push, return to IDLE (abort).
REQ-020 WAIT or ACK with data != ref register -> err set; transfer continues; ACK-cycle value pushed.
REQ-021 ACK: on the closing edge, push data if rd_full=0 or rd_en=1 the same cycle; otherwise drop the byte and set ovf; always -> DONE.
REQ-022 DONE: dValid=0 -> IDLE; dValid=1 -> set err, stay in DONE until dValid=0; no new transfer starts from DONE.
REQ-023 Minimum transfer is one idle cycle (DONE) between consecutive dValid-high bursts; back-to-back transfers at this rate SHALL be accepted without loss.
REQ-024 FIFO: pop when rd_en=1 and rd_empty=0; rd_en on empty ignored, no underflow, level unchanged.
REQ-025 Simultaneous push and pop: level unchanged, order preserved, legal even when full.
REQ-026 Pointers wrap modulo FIFO_DEPTH; level saturates neither above FIFO_DEPTH nor below 0.
REQ-027 err_clr coincident with a new error event: the set wins (flag stays 1).
REQ-028 ACK_DLY outside 1..3 SHALL be rejected at elaboration.

Reset
REQ-029 reset=1 at a clock edge: state=IDLE, dAck=0, counter=0, FIFO emptied (level=0, rd_empty=1, rd_full=0), ovf=0, err=0, rd_data=0.
REQ-030 Reset mid-transfer aborts it without push or error; a dValid still high after reset releases is treated as a new transfer from IDLE.

Structure
REQ-031 Shared package bus_protocol_pkg holds DATA_W=8, state enum type, ACK_DLY_MIN=1, ACK_DLY_MAX=3.
REQ-032 FIFO implemented as sub-module bus_rx_fifo (push, pop, data in/out, full, empty, level); FSM and error logic in the top.

Verification
REQ-033 ACK_DLY=2, dValid high from cycle 0, data=0xA5 -> dAck=1 only in cycle 3; master drops dValid in cycle 4 -> rd_data=0xA5, level=1, err=0.
REQ-034 Five transfers 0x01..0x05, no rd_en, FIFO_DEPTH=4 -> level=4, rd_full=1, ovf=1; pops return 0x01..0x04 in order.
REQ-035 ACK_DLY=1, dValid dropped in cycle 1 before dAck -> no dAck, err=1, level=0; err_clr -> err=0.
REQ-036 data changes 0x3C->0x3D in WAIT -> err=1, dAck still issued, 0x3D pushed.
REQ-037 FIFO full, rd_en asserted in ACK cycle -> level stays 4, ovf=0, new byte at tail.
REQ-038 reset asserted in WAIT -> dAck never rises, level=0, err=0; dValid still high after release -> dAck ACK_DLY+1 cycles later.
